// File: rtl/lift_pkg.sv
// Shared types and constants for the lift scheduler, the LCD status driver and the HEX floor decoders.
package lift_pkg;

  localparam int FLOOR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOOR,
    ST_UP,
    ST_DOWN,
    ST_HOME
  } state_t;

  localparam logic [1:0] PARADO   = 2'd0;
  localparam logic [1:0] SUBINDO  = 2'd1;
  localparam logic [1:0] DESCENDO = 2'd2;
  localparam logic [1:0] INATIVO  = 2'd3;

  // Active-low gfedcba patterns for digits 0..9, indexed by digit.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  function automatic logic [6:0] floor_to_seg(input logic [FLOOR_W-1:0] f);
    return (f < 4'd10) ? SEG_DIGITS[f] : SEG_BLANK;
  endfunction

  function automatic logic [1:0] state_code(input state_t s);
    logic [1:0] code;
    case (s)
      ST_UP:   code = SUBINDO;
      ST_DOWN: code = DESCENDO;
      ST_HOME: code = INATIVO;
      default: code = PARADO;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/lift_request_scheduler_if.sv
// Floor request port: a one-cycle strobe with its floor, answered by a one-cycle error pulse.
interface lift_request_scheduler_if;
  import lift_pkg::*;

  // No ready: every strobe is consumed in the cycle it is seen; an
  // out-of-range floor is answered by oREQ_ERR on the following cycle.
  logic               iREQ_VALID;
  logic [FLOOR_W-1:0] iREQ_FLOOR;
  logic               oREQ_ERR;

  modport master (output iREQ_VALID, output iREQ_FLOOR, input oREQ_ERR);
  modport slave  (input iREQ_VALID, input iREQ_FLOOR, output oREQ_ERR);
endinterface

// File: rtl/lift_tick_gen.sv
// Step-tick generator: a TICK_DIV down-counter that pulses tick for one cycle when it hits zero.
module lift_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (tick) cnt <= CW'(TICK_DIV - 1);
    else cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/lift_request_scheduler.sv
// SCAN-order floor scheduler and car sequencer. Optional homing to floor 0 after an idle
// period is enabled by defining LIFT_HOME_RETURN_EN.
module lift_request_scheduler
  import lift_pkg::*;
#(
  parameter int N_FLOORS   = 9,
  parameter int TICK_DIV   = 50_000_000,
  parameter int DOOR_TICKS = 3,
  parameter int IDLE_TICKS = 5
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  lift_request_scheduler_if.slave   req,
  output logic [FLOOR_W-1:0]        oFLOOR,
  output logic [1:0]                oSTATE,
  output logic                      oDOOR_OPEN,
  output logic [N_FLOORS-1:0]       oPENDING,
  output logic                      oSTATE_CHG,
  output state_t                    fsm_state
);
  logic tick;

  lift_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(iCLK), .rst_n(iRST_N), .tick(tick));

  state_t                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d, floor_up, floor_dn;
  logic [N_FLOORS-1:0]   pend_q, pend_d, set_mask, clr_mask, above_m, below_m;
  logic [7:0]            door_cnt_q, door_cnt_d, idle_cnt_q, idle_cnt_d;
  logic                  dir_up_q, dir_up_d, req_err_q, state_chg_q;
  logic                  in_range, req_here, any_above, any_below;

  assign floor_up  = floor_q + 4'd1;
  assign floor_dn  = floor_q - 4'd1;
  assign in_range  = req.iREQ_VALID && (int'(req.iREQ_FLOOR) < N_FLOORS);
  // A request for the car's own floor while stopped reopens the door instead of queueing.
  assign req_here  = in_range && (req.iREQ_FLOOR == floor_q) &&
                     (state_q == ST_IDLE || state_q == ST_DOOR);
  assign any_above = |(pend_q & above_m);
  assign any_below = |(pend_q & below_m);

  always_comb begin
    set_mask = '0;
    above_m  = '0;
    below_m  = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      set_mask[i] = in_range && !req_here && (int'(req.iREQ_FLOOR) == i);
      above_m[i]  = (i > int'(floor_q));
      below_m[i]  = (i < int'(floor_q));
    end
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    door_cnt_d = door_cnt_q;
    idle_cnt_d = idle_cnt_q;
    dir_up_d   = dir_up_q;
    clr_mask   = '0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (any_above && (dir_up_q || !any_below)) begin
            state_d  = ST_UP;
            dir_up_d = 1'b1;
          end else if (any_below) begin
            state_d  = ST_DOWN;
            dir_up_d = 1'b0;
          end else begin
            if (idle_cnt_q != 8'(IDLE_TICKS)) idle_cnt_d = idle_cnt_q + 8'd1;
`ifdef LIFT_HOME_RETURN_EN
            if (floor_q != '0 && idle_cnt_q == 8'(IDLE_TICKS - 1)) begin
              state_d  = ST_HOME;
              dir_up_d = 1'b0;
            end
`endif
          end
        end
        ST_UP: begin
          if (!any_above) state_d = ST_IDLE;
          else begin
            floor_d = floor_up;
            if (pend_q[floor_up]) begin
              clr_mask[floor_up] = 1'b1;
              state_d            = ST_DOOR;
              door_cnt_d         = '0;
            end
          end
        end
        ST_DOWN: begin
          if (!any_below) state_d = ST_IDLE;
          else begin
            floor_d = floor_dn;
            if (pend_q[floor_dn]) begin
              clr_mask[floor_dn] = 1'b1;
              state_d            = ST_DOOR;
              door_cnt_d         = '0;
            end
          end
        end
        ST_DOOR: begin
          if (door_cnt_q == 8'(DOOR_TICKS - 1)) begin
            if (dir_up_q ? any_above : any_below) state_d = dir_up_q ? ST_UP : ST_DOWN;
            else if (dir_up_q ? any_below : any_above) begin
              state_d  = dir_up_q ? ST_DOWN : ST_UP;
              dir_up_d = !dir_up_q;
            end else state_d = ST_IDLE;
          end else door_cnt_d = door_cnt_q + 8'd1;
        end
        ST_HOME: begin
`ifdef LIFT_HOME_RETURN_EN
          if (any_above) begin
            state_d  = ST_UP;
            dir_up_d = 1'b1;
          end else if (floor_q == '0) state_d = ST_IDLE;
          else begin
            floor_d = floor_dn;
            if (pend_q[floor_dn]) begin
              clr_mask[floor_dn] = 1'b1;
              state_d            = ST_DOOR;
              door_cnt_d         = '0;
            end else if (floor_dn == '0) state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (req_here) begin
      state_d    = ST_DOOR;
      door_cnt_d = '0;
    end
    if (in_range || state_q != ST_IDLE) idle_cnt_d = '0;
    // Clearing the arrival floor beats a same-cycle request for it.
    pend_d = (pend_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      floor_q     <= '0;
      pend_q      <= '0;
      door_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      dir_up_q    <= 1'b1;
      req_err_q   <= 1'b0;
      state_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      pend_q      <= pend_d;
      door_cnt_q  <= door_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      dir_up_q    <= dir_up_d;
      req_err_q   <= req.iREQ_VALID && !in_range;
      state_chg_q <= (state_code(state_d) != state_code(state_q));
    end
  end

  assign req.oREQ_ERR = req_err_q;
  assign oFLOOR       = floor_q;
  assign oSTATE       = state_code(state_q);
  assign oDOOR_OPEN   = (state_q == ST_DOOR);
  assign oPENDING     = pend_q;
  assign oSTATE_CHG   = state_chg_q;
  assign fsm_state    = state_q;
endmodule
